// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and constants for the GPR writeback queue: word and register
// sizes, the queue entry layout and a destination-decode helper.
package reg_writeback_queue_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int NUM_REGS   = 4;
  localparam int REG_ADDR_W = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_SIZE-1:0]  word_t;

  // One queued writeback: destination GPR and the value to write there.
  typedef struct packed {
    reg_addr_t dest;
    word_t     data;
  } wb_entry_t;

  // One-hot decode of a GPR address, used to build the pending-write mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bundle of request, write-port, bypass and status signals around the
// writeback queue. The slave side is the queue; the master side is the
// surrounding pipeline (EX/MEM sources, register file, decode/hazard logic).
interface reg_writeback_queue_if
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                flush;
  logic                mem_valid;
  reg_addr_t           mem_reg;
  word_t               mem_data;
  logic                alu_valid;
  reg_addr_t           alu_reg;
  word_t               alu_data;
  logic                in_ready;
  logic                reg_write;
  reg_addr_t           write_reg;
  word_t               write_data;
  reg_addr_t           byp_addr1;
  reg_addr_t           byp_addr2;
  logic                byp_hit1;
  word_t               byp_data1;
  logic                byp_hit2;
  word_t               byp_data2;
  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    count;

  modport master (
    output flush, mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           byp_addr1, byp_addr2,
    input  in_ready, reg_write, write_reg, write_data,
           byp_hit1, byp_data1, byp_hit2, byp_data2, pending, count
  );

  modport slave (
    input  flush, mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           byp_addr1, byp_addr2,
    output in_ready, reg_write, write_reg, write_data,
           byp_hit1, byp_data1, byp_hit2, byp_data2, pending, count
  );

endinterface

// File: rtl/reg_writeback_queue_wb_bypass_match.sv
// Combinational bypass lookup over the queue contents. Entries arrive in age
// order (index 0 = oldest, the head); the youngest valid entry whose
// destination matches the lookup address supplies the data.
module reg_writeback_queue_wb_bypass_match
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] i_entries,
  input  logic      [DEPTH-1:0] i_valid,
  input  reg_addr_t             i_addr,
  output logic                  o_hit,
  output word_t                 o_data
);

  // Scan oldest to youngest so a later (younger) match overrides earlier ones.
  always_comb begin
    // NOTE: every output gets a default before the loop; without it a path
    // with no match would hold the old value and infer a latch.
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_valid[i] && (i_entries[i].dest == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[i].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue in front of the GPR write port. Accepts up to two requests
// per cycle (mem older than alu), retires one entry per cycle to the
// register file, and exposes bypass data and a pending-write mask covering
// every entry that is queued but not yet retired.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_writeback_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  wb_entry_t r_entries [DEPTH];
  ptr_t      r_head;
  ptr_t      r_tail;
  cnt_t      r_count;

  logic                  w_in_ready;
  logic                  w_pop;
  logic                  w_acc_mem;
  logic                  w_acc_alu;
  logic [1:0]            w_num_acc;
  ptr_t                  w_alu_slot;
  wb_entry_t [DEPTH-1:0] w_age_entries;
  logic      [DEPTH-1:0] w_age_valid;
  logic [NUM_REGS-1:0]   w_pending;

  // Two free slots are needed because both sources may present in one cycle;
  // decoded from the registered count only, so it never depends on inputs.
  assign w_in_ready = (r_count <= cnt_t'(DEPTH - 2));
  assign w_pop      = (r_count != '0);
  assign w_acc_mem  = w_in_ready && bus.mem_valid;
  assign w_acc_alu  = w_in_ready && bus.alu_valid;
  assign w_num_acc  = {1'b0, w_acc_mem} + {1'b0, w_acc_alu};
  // The alu request lands behind the mem request when both are accepted.
  assign w_alu_slot = w_acc_mem ? (r_tail + ptr_t'(1)) : r_tail;

  // Pointer and occupancy update; flush empties the queue and drops requests.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is assigned with <= so each flop samples the pre-edge values
    // of the others, independent of statement order.
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + ptr_t'(w_pop);
      r_tail  <= r_tail + ptr_t'(w_num_acc);
      r_count <= r_count + cnt_t'(w_num_acc) - cnt_t'(w_pop);
    end
  end

  // Entry storage: written at the tail slot(s) of accepted requests.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; an entry is only meaningful while
    // inside [head, head+count), and count itself is reset.
    if (!reset && !bus.flush) begin
      if (w_acc_mem) r_entries[r_tail]     <= '{dest: bus.mem_reg, data: bus.mem_data};
      if (w_acc_alu) r_entries[w_alu_slot] <= '{dest: bus.alu_reg, data: bus.alu_data};
    end
  end

  // Age-ordered view of the ring: index 0 is the head (oldest entry).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_age_entries[i] = r_entries[r_head + ptr_t'(i)];
      w_age_valid[i]   = (cnt_t'(i) < r_count);
    end
  end

  // Pending-write mask: one bit per GPR targeted by any queued entry.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_age_valid[i]) w_pending = w_pending | reg_onehot(w_age_entries[i].dest);
    end
  end

  reg_writeback_queue_wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
    .i_entries (w_age_entries),
    .i_valid   (w_age_valid),
    .i_addr    (bus.byp_addr1),
    .o_hit     (bus.byp_hit1),
    .o_data    (bus.byp_data1)
  );

  reg_writeback_queue_wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
    .i_entries (w_age_entries),
    .i_valid   (w_age_valid),
    .i_addr    (bus.byp_addr2),
    .o_hit     (bus.byp_hit2),
    .o_data    (bus.byp_data2)
  );

  // Write port presents the head entry and is forced to zero when empty.
  assign bus.in_ready   = w_in_ready;
  assign bus.reg_write  = w_pop;
  assign bus.write_reg  = w_pop ? w_age_entries[0].dest : '0;
  assign bus.write_data = w_pop ? w_age_entries[0].data : '0;
  assign bus.pending    = w_pending;
  assign bus.count      = r_count;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue. A queue-based reference model
// tracks accepted-but-unretired writes; the stimulus process pushes each
// accepted request into a scoreboard, and a negedge monitor pops and compares
// whenever the DUT asserts reg_write, alongside status and bypass checks.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  wb_entry_t model_q[$];
  wb_entry_t sb_q[$];
  word_t     model_gpr [NUM_REGS];
  word_t     tb_gpr    [NUM_REGS];
  logic      last_accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest queued value for a register, straight from the model queue.
  task automatic byp_model(input reg_addr_t a, output logic hit, output word_t d);
    hit = 1'b0;
    d   = '0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].dest == a) begin
        hit = 1'b1;
        d   = model_q[i].data;
        break;
      end
    end
  endtask

  task automatic clear_model();
    model_q.delete();
    sb_q.delete();
  endtask

  // Reference behaviour at a clock edge, using the inputs held across it.
  task automatic model_edge();
    logic      ready;
    wb_entry_t e;
    if (reset) begin
      clear_model();
      last_accepted = 1'b1;
    end else if (bus.flush) begin
      if (model_q.size() > 0) model_gpr[model_q[0].dest] = model_q[0].data;
      clear_model();
      last_accepted = 1'b1;
    end else begin
      ready = (DEPTH - model_q.size() >= 2);
      if (model_q.size() > 0) begin
        e = model_q.pop_front();
        model_gpr[e.dest] = e.data;
      end
      if (ready && bus.mem_valid) begin
        model_q.push_back('{dest: bus.mem_reg, data: bus.mem_data});
        sb_q.push_back('{dest: bus.mem_reg, data: bus.mem_data});
      end
      if (ready && bus.alu_valid) begin
        model_q.push_back('{dest: bus.alu_reg, data: bus.alu_data});
        sb_q.push_back('{dest: bus.alu_reg, data: bus.alu_data});
      end
      last_accepted = ready;
    end
  endtask

  task automatic set_req(input logic mv, input reg_addr_t mr, input word_t md,
                         input logic av, input reg_addr_t ar, input word_t ad,
                         input logic fl);
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
    bus.flush     = fl;
  endtask

  task automatic idle();
    set_req(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    bus.byp_addr1 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
    bus.byp_addr2 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
  endtask

  // Monitor: compares the write port against the scoreboard and the status
  // and bypass outputs against the reference model.
  always @(negedge clk) begin : monitor
    wb_entry_t           e;
    logic                hit;
    word_t               d;
    logic [NUM_REGS-1:0] pend;
    check("reg_write", 32'(bus.reg_write), 32'(model_q.size() != 0));
    if (bus.reg_write && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("write_reg", 32'(bus.write_reg), 32'(e.dest));
      check("write_data", 32'(bus.write_data), 32'(e.data));
      tb_gpr[bus.write_reg] = bus.write_data;
    end else if (!bus.reg_write) begin
      check("idle_write_reg", 32'(bus.write_reg), 32'(0));
      check("idle_write_data", 32'(bus.write_data), 32'(0));
    end
    check("count", 32'(bus.count), 32'(model_q.size()));
    check("in_ready", 32'(bus.in_ready), 32'(DEPTH - model_q.size() >= 2));
    pend = '0;
    foreach (model_q[i]) pend[model_q[i].dest] = 1'b1;
    check("pending", 32'(bus.pending), 32'(pend));
    byp_model(bus.byp_addr1, hit, d);
    check("byp_hit1", 32'(bus.byp_hit1), 32'(hit));
    check("byp_data1", 32'(bus.byp_data1), 32'(d));
    byp_model(bus.byp_addr2, hit, d);
    check("byp_hit2", 32'(bus.byp_hit2), 32'(hit));
    check("byp_data2", 32'(bus.byp_data2), 32'(d));
  end

  initial begin
    logic      mv, av, fl;
    reg_addr_t mr, ar;
    word_t     md, ad;
    for (int r = 0; r < NUM_REGS; r++) begin
      model_gpr[r] = '0;
      tb_gpr[r]    = '0;
    end
    reset = 1'b1;
    last_accepted = 1'b1;
    idle();
    bus.byp_addr1 = '0;
    bus.byp_addr2 = '0;
    step();
    step();
    reset = 1'b0;

    // Reset then idle.
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_pending", 32'(bus.pending), 32'(0));
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_reg_write", 32'(bus.reg_write), 32'(0));

    // Single alu write: presented after the accepting edge, then empty.
    set_req(1'b0, '0, '0, 1'b1, 2'd2, 16'h1234, 1'b0);
    step();
    idle();
    check("single_reg_write", 32'(bus.reg_write), 32'(1));
    check("single_write_reg", 32'(bus.write_reg), 32'(2));
    check("single_write_data", 32'(bus.write_data), 32'h1234);
    step();
    check("single_drained", 32'(bus.reg_write), 32'(0));
    check("gpr2", 32'(tb_gpr[2]), 32'h1234);

    // Same-cycle mem+alu to one register: younger (alu) wins the bypass.
    set_req(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd1, 16'h5555, 1'b0);
    step();
    idle();
    bus.byp_addr1 = 2'd1;
    #1;
    check("dual_byp_hit", 32'(bus.byp_hit1), 32'(1));
    check("dual_byp_data", 32'(bus.byp_data1), 32'h5555);
    check("dual_first_write", 32'(bus.write_data), 32'hAAAA);
    repeat (3) step();
    check("gpr1", 32'(tb_gpr[1]), 32'h5555);

    // Both sources valid every cycle; requests held while not accepted.
    for (int c = 0; c < 16; c++) begin
      if (last_accepted)
        set_req(1'b1, reg_addr_t'($urandom), word_t'($urandom),
                1'b1, reg_addr_t'($urandom), word_t'($urandom), 1'b0);
      step();
    end
    idle();
    repeat (5) step();

    // Flush with three entries queued and an alu request present.
    set_req(1'b1, 2'd0, 16'h0101, 1'b1, 2'd3, 16'h0303, 1'b0);
    step();
    set_req(1'b1, 2'd1, 16'h1111, 1'b1, 2'd2, 16'h2222, 1'b0);
    step();
    check("pre_flush_count", 32'(bus.count), 32'(3));
    set_req(1'b0, '0, '0, 1'b1, 2'd3, 16'hDEAD, 1'b1);
    step();
    idle();
    check("flush_count", 32'(bus.count), 32'(0));
    check("flush_reg_write", 32'(bus.reg_write), 32'(0));
    check("flush_pending", 32'(bus.pending), 32'(0));
    repeat (2) step();

    // Randomized traffic with occasional flushes; sources hold when refused.
    for (int c = 0; c < 400; c++) begin
      if (last_accepted) begin
        mv = ($urandom_range(0, 3) != 0);
        av = ($urandom_range(0, 3) != 0);
        mr = reg_addr_t'($urandom);
        ar = reg_addr_t'($urandom);
        md = word_t'($urandom);
        ad = word_t'($urandom);
        fl = ($urandom_range(0, 24) == 0);
        set_req(mv, mr, md, av, ar, ad, fl);
      end else begin
        bus.flush = 1'b0;
      end
      step();
    end
    idle();
    repeat (5) step();

    // Asynchronous reset while two entries are queued.
    set_req(1'b1, 2'd2, 16'hBEEF, 1'b1, 2'd3, 16'hCAFE, 1'b0);
    step();
    idle();
    #1;
    reset = 1'b1;
    clear_model();
    #1;
    check("arst_reg_write", 32'(bus.reg_write), 32'(0));
    check("arst_write_data", 32'(bus.write_data), 32'(0));
    check("arst_count", 32'(bus.count), 32'(0));
    check("arst_pending", 32'(bus.pending), 32'(0));
    check("arst_in_ready", 32'(bus.in_ready), 32'(1));
    step();
    reset = 1'b0;
    repeat (4) step();

    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    for (int r = 0; r < NUM_REGS; r++)
      check($sformatf("gpr_final%0d", r), 32'(tb_gpr[r]), 32'(model_gpr[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
